// File: rtl/sys_defs.sv
// Shared types for the branch checkpoint stack: slot mask, map table,
// free list, LSQ pointers and the per-branch checkpoint packet.
package sys_defs;
    localparam int B_MASK_WIDTH      = 4;
    localparam int ARCH_REG_SZ       = 32;
    localparam int PHYS_REG_SZ       = 64;
    localparam int PHYS_REG_IDX_BITS = $clog2(PHYS_REG_SZ);
    localparam int ROB_SZ_BITS       = 5;
    localparam int SQ_SZ             = 8;

    typedef logic [B_MASK_WIDTH-1:0]      B_MASK;
    typedef logic [PHYS_REG_IDX_BITS-1:0] PHYS_REG_IDX;
    typedef logic [$clog2(SQ_SZ)-1:0]     SQ_POINTER;
    typedef logic [SQ_SZ-1:0]             SQ_MASK;
    typedef logic [PHYS_REG_SZ-1:0]       FREE_LIST;
    typedef PHYS_REG_IDX [ARCH_REG_SZ-1:0] MAP_TABLE;

    // b_m holds the slots that were live (older) when this branch dispatched
    typedef struct packed {
        MAP_TABLE               map_table;
        FREE_LIST               free_list;
        logic [ROB_SZ_BITS-1:0] rob_tail;
        SQ_POINTER              sq_tail;
        SQ_MASK                 sq_mask;
        B_MASK                  b_m;
    } BS_ENTRY_PACKET;
endpackage

// File: rtl/bs_checkpoint.sv
// One checkpoint slot: loads a new checkpoint on allocation, otherwise keeps
// its free list current with retirement and drops resolved older branches.
module bs_checkpoint
    import sys_defs::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           write_en,
    input  BS_ENTRY_PACKET write_data,
    input  logic           valid,
    input  FREE_LIST       retire_free_mask,
    input  logic           clear_en,
    input  B_MASK          clear_mask,
    output BS_ENTRY_PACKET entry
);

    // Allocation wins over the merge/clear so a slot reused in the resolve cycle holds fresh data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry <= '0;
        end else if (write_en) begin
            entry           <= write_data;
            entry.free_list <= write_data.free_list | retire_free_mask;
        end else if (valid) begin
            entry.free_list <= entry.free_list | retire_free_mask;
            if (clear_en) begin
                entry.b_m <= entry.b_m & ~clear_mask;
            end
        end
    end

endmodule

// File: rtl/branch_stack.sv
// Branch checkpoint stack: tracks live branch slots, clears a slot on a
// correct resolve and presents the checkpoint for same-cycle restore on a
// mispredict, together with the squash mask for younger work.
module branch_stack
    import sys_defs::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  BS_ENTRY_PACKET [B_MASK_WIDTH-1:0] dispatch_entries,
    input  B_MASK                        dispatch_b_mask,
    input  logic                         resolve_valid,
    input  B_MASK                        resolve_b_id,
    input  logic                         resolve_mispredict,
    input  logic [31:0]                  resolve_target_PC,
    input  FREE_LIST                     retire_free_mask,
    output B_MASK                        b_mask_combinational,
    output logic                         restore_valid,
    output MAP_TABLE                     map_table_restore,
    output FREE_LIST                     free_list_restore,
    output logic [ROB_SZ_BITS-1:0]       rob_tail_restore,
    output SQ_POINTER                    sq_tail_restore,
    output SQ_MASK                       sq_mask_restore,
    output logic [31:0]                  redirect_PC,
    output B_MASK                        b_mask_clear,
    output B_MASK                        b_mask_squash
);

    B_MASK          b_mask;
    BS_ENTRY_PACKET entries [B_MASK_WIDTH];
    BS_ENTRY_PACKET sel_entry;
    B_MASK          younger;
    B_MASK          write_en;
    logic           hit;
    logic           mispredict;
    logic           correct;

    assign hit        = resolve_valid & (|(resolve_b_id & b_mask));
    assign mispredict = hit & resolve_mispredict;
    assign correct    = hit & ~resolve_mispredict;

    // Dispatch sends nothing while restoring, so writes are dropped on a mispredict
    assign write_en = mispredict ? '0 : (dispatch_b_mask & ~b_mask_combinational);

    // One-hot AND-OR select of the resolving slot's checkpoint
    always_comb begin
        sel_entry = '0;
        for (int j = 0; j < B_MASK_WIDTH; j++) begin
            if (resolve_b_id[j]) begin
                sel_entry = BS_ENTRY_PACKET'(sel_entry | entries[j]);
            end
        end
    end

    // Live slots whose checkpoint lists the resolving branch as older are younger than it
    always_comb begin
        younger = '0;
        for (int j = 0; j < B_MASK_WIDTH; j++) begin
            younger[j] = (|(entries[j].b_m & resolve_b_id)) & b_mask[j];
        end
    end

    // Zero-latency resolve outputs: clear on correct, restore and squash on mispredict
    always_comb begin
        b_mask_combinational = b_mask;
        b_mask_clear         = '0;
        b_mask_squash        = '0;
        restore_valid        = 1'b0;
        map_table_restore    = '0;
        free_list_restore    = '0;
        rob_tail_restore     = '0;
        sq_tail_restore      = '0;
        sq_mask_restore      = '0;
        redirect_PC          = '0;
        if (correct) begin
            b_mask_combinational = b_mask & ~resolve_b_id;
            b_mask_clear         = resolve_b_id;
        end else if (mispredict) begin
            b_mask_combinational = sel_entry.b_m;
            b_mask_squash        = resolve_b_id | younger;
            restore_valid        = 1'b1;
            map_table_restore    = sel_entry.map_table;
            free_list_restore    = sel_entry.free_list | retire_free_mask;
            rob_tail_restore     = sel_entry.rob_tail;
            sq_tail_restore      = sel_entry.sq_tail;
            sq_mask_restore      = sel_entry.sq_mask;
            redirect_PC          = resolve_target_PC;
        end
    end

    // Live mask rolls back to the branch's older set on mispredict, else follows dispatch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            b_mask <= '0;
        end else if (mispredict) begin
            b_mask <= sel_entry.b_m;
        end else begin
            b_mask <= dispatch_b_mask;
        end
    end

    for (genvar j = 0; j < B_MASK_WIDTH; j++) begin : g_slot
        bs_checkpoint u_slot (
            .clock            (clock),
            .reset            (reset),
            .write_en         (write_en[j]),
            .write_data       (dispatch_entries[j]),
            .valid            (b_mask[j]),
            .retire_free_mask (retire_free_mask),
            .clear_en         (correct),
            .clear_mask       (resolve_b_id),
            .entry            (entries[j])
        );
    end

endmodule

// File: tb/tb_branch_stack.sv
// Bench for branch_stack. The reference model keeps live branches as an
// age-ordered queue of slot ids plus the stored checkpoint per slot; older,
// younger and restore masks are derived from queue position.
module tb_branch_stack;
    import sys_defs::*;

    logic                              clock;
    logic                              reset;
    BS_ENTRY_PACKET [B_MASK_WIDTH-1:0] dispatch_entries;
    B_MASK                             dispatch_b_mask;
    logic                              resolve_valid;
    B_MASK                             resolve_b_id;
    logic                              resolve_mispredict;
    logic [31:0]                       resolve_target_PC;
    FREE_LIST                          retire_free_mask;
    B_MASK                             b_mask_combinational;
    logic                              restore_valid;
    MAP_TABLE                          map_table_restore;
    FREE_LIST                          free_list_restore;
    logic [ROB_SZ_BITS-1:0]            rob_tail_restore;
    SQ_POINTER                         sq_tail_restore;
    SQ_MASK                            sq_mask_restore;
    logic [31:0]                       redirect_PC;
    B_MASK                             b_mask_clear;
    B_MASK                             b_mask_squash;

    int checks   = 0;
    int failures = 0;

    int             q[$];
    BS_ENTRY_PACKET m_ent [B_MASK_WIDTH];
    B_MASK          e_comb, e_clear, e_squash;
    logic           e_rv;
    BS_ENTRY_PACKET e_ent;
    logic [31:0]    e_red;
    logic           hit_g, mis_g;
    int             p_g;

    branch_stack dut (
        .clock                (clock),
        .reset                (reset),
        .dispatch_entries     (dispatch_entries),
        .dispatch_b_mask      (dispatch_b_mask),
        .resolve_valid        (resolve_valid),
        .resolve_b_id         (resolve_b_id),
        .resolve_mispredict   (resolve_mispredict),
        .resolve_target_PC    (resolve_target_PC),
        .retire_free_mask     (retire_free_mask),
        .b_mask_combinational (b_mask_combinational),
        .restore_valid        (restore_valid),
        .map_table_restore    (map_table_restore),
        .free_list_restore    (free_list_restore),
        .rob_tail_restore     (rob_tail_restore),
        .sq_tail_restore      (sq_tail_restore),
        .sq_mask_restore      (sq_mask_restore),
        .redirect_PC          (redirect_PC),
        .b_mask_clear         (b_mask_clear),
        .b_mask_squash        (b_mask_squash)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic BS_ENTRY_PACKET rand_entry();
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
        return BS_ENTRY_PACKET'(r[$bits(BS_ENTRY_PACKET)-1:0]);
    endfunction

    function automatic FREE_LIST rand_retire();
        FREE_LIST r;
        r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        if ($urandom_range(1, 0) == 0) r = '0;
        return r;
    endfunction

    function automatic B_MASK live_mask();
        B_MASK m = '0;
        foreach (q[i]) m[q[i]] = 1'b1;
        return m;
    endfunction

    // Expected zero-latency outputs from the age-ordered live queue
    task automatic model_eval();
        int k = -1;
        p_g   = -1;
        if (resolve_valid) begin
            for (int s = 0; s < B_MASK_WIDTH; s++) if (resolve_b_id[s]) k = s;
            foreach (q[i]) if (q[i] == k) p_g = i;
        end
        hit_g    = resolve_valid && (p_g >= 0);
        mis_g    = hit_g && resolve_mispredict;
        e_comb   = live_mask();
        e_clear  = '0;
        e_squash = '0;
        e_rv     = 1'b0;
        e_ent    = '0;
        e_red    = '0;
        if (hit_g && !resolve_mispredict) begin
            e_comb[k]  = 1'b0;
            e_clear[k] = 1'b1;
        end else if (mis_g) begin
            e_comb = '0;
            foreach (q[i]) begin
                if (i < p_g) e_comb[q[i]] = 1'b1;
                else         e_squash[q[i]] = 1'b1;
            end
            e_rv            = 1'b1;
            e_ent           = m_ent[k];
            e_ent.free_list = m_ent[k].free_list | retire_free_mask;
            e_red           = resolve_target_PC;
        end
    endtask

    task automatic model_commit();
        B_MASK al_m;
        if (mis_g) begin
            while (q.size() > p_g) void'(q.pop_back());
            foreach (q[i]) m_ent[q[i]].free_list = m_ent[q[i]].free_list | retire_free_mask;
        end else begin
            al_m = dispatch_b_mask & ~e_comb;
            if (hit_g) q.delete(p_g);
            foreach (q[i]) m_ent[q[i]].free_list = m_ent[q[i]].free_list | retire_free_mask;
            for (int s = 0; s < B_MASK_WIDTH; s++) begin
                if (al_m[s]) begin
                    q.push_back(s);
                    m_ent[s]           = dispatch_entries[s];
                    m_ent[s].free_list = dispatch_entries[s].free_list | retire_free_mask;
                end
            end
        end
    endtask

    // rs: resolving slot (-1 none); al: slot to allocate (-1 none, -2 any free slot)
    task automatic drive(input int rs, input bit mis, input logic [31:0] tgt, input int al,
                         input BS_ENTRY_PACKET ne, input FREE_LIST ret);
        int a = al;
        resolve_valid      = (rs >= 0);
        resolve_b_id       = (rs >= 0) ? B_MASK'(1 << rs) : B_MASK'($urandom);
        resolve_mispredict = mis;
        resolve_target_PC  = tgt;
        retire_free_mask   = ret;
        for (int j = 0; j < B_MASK_WIDTH; j++) dispatch_entries[j] = rand_entry();
        model_eval();
        if (e_rv) begin
            dispatch_b_mask = B_MASK'($urandom);
        end else begin
            dispatch_b_mask = e_comb;
            if (a == -2) begin
                a = -1;
                if ($urandom_range(1, 0) == 1)
                    for (int s = 0; s < B_MASK_WIDTH; s++) if (!e_comb[s] && a < 0) a = s;
            end
            if (a >= 0) begin
                ne.b_m              = e_comb;
                dispatch_b_mask[a]  = 1'b1;
                dispatch_entries[a] = ne;
            end
        end
        #3;
        check("b_mask_comb", b_mask_combinational, e_comb);
        check("restore_valid", restore_valid, e_rv);
        check("map_restore", map_table_restore, e_ent.map_table);
        check("free_restore", free_list_restore, e_ent.free_list);
        check("rob_tail", rob_tail_restore, e_ent.rob_tail);
        check("sq_tail", sq_tail_restore, e_ent.sq_tail);
        check("sq_mask", sq_mask_restore, e_ent.sq_mask);
        check("redirect_pc", redirect_PC, e_red);
        check("clear", b_mask_clear, e_clear);
        check("squash", b_mask_squash, e_squash);
    endtask

    task automatic tick();
        @(posedge clock);
        model_commit();
        #1;
    endtask

    initial begin
        BS_ENTRY_PACKET ent, ent1, ent5;
        reset              = 1'b1;
        dispatch_entries   = '0;
        dispatch_b_mask    = '0;
        resolve_valid      = 1'b0;
        resolve_b_id       = '0;
        resolve_mispredict = 1'b0;
        resolve_target_PC  = '0;
        retire_free_mask   = '0;
        #12 reset = 1'b0;
        @(posedge clock);
        #1;

        // reset state
        drive(-1, 0, 0, -1, '0, '0);
        check("reset_comb", b_mask_combinational, 4'b0000);
        tick();

        // correct resolve of a single branch
        ent = rand_entry();
        ent.map_table[5] = 6'd40;
        drive(-1, 0, 0, 0, ent, '0); tick();
        drive(0, 0, 0, -1, '0, '0);
        check("t2_clear", b_mask_clear, 4'b0001);
        check("t2_comb", b_mask_combinational, 4'b0000);
        check("t2_rv", restore_valid, 1'b0);
        tick();

        // mispredict of a middle branch
        drive(-1, 0, 0, 0, rand_entry(), '0); tick();
        ent1 = rand_entry();
        drive(-1, 0, 0, 1, ent1, '0); tick();
        drive(-1, 0, 0, 2, rand_entry(), '0); tick();
        drive(1, 1, 32'h100, -1, '0, '0);
        check("t3_rv", restore_valid, 1'b1);
        check("t3_map", map_table_restore, ent1.map_table);
        check("t3_pc", redirect_PC, 32'h100);
        check("t3_squash", b_mask_squash, 4'b0110);
        tick();
        drive(-1, 0, 0, -1, '0, '0);
        check("t3_bmask", b_mask_combinational, 4'b0001);
        tick();

        // retirement merged into a held checkpoint
        drive(0, 0, 0, -1, '0, '0); tick();
        ent = rand_entry();
        ent.free_list[12] = 1'b0;
        drive(-1, 0, 0, 0, ent, '0); tick();
        drive(-1, 0, 0, -1, '0, FREE_LIST'(1) << 12); tick();
        drive(0, 1, 32'h200, -1, '0, '0);
        check("t4_fl12", free_list_restore[12], 1'b1);
        tick();

        // full stack, same-slot reuse on a correct resolve
        for (int s = 0; s < 4; s++) begin
            drive(-1, 0, 0, s, rand_entry(), rand_retire()); tick();
        end
        check("t5_full", b_mask_combinational, 4'b1111);
        ent5 = rand_entry();
        drive(2, 0, 0, 2, ent5, rand_retire()); tick();
        drive(-1, 0, 0, -1, '0, '0);
        check("t5_bmask", b_mask_combinational, 4'b1111);
        tick();
        drive(2, 1, 32'h300, -1, '0, '0);
        check("t5_newmap", map_table_restore, ent5.map_table);
        check("t5_newbm", b_mask_combinational, 4'b1011);
        tick();
        drive(3, 1, 32'h400, -1, '0, '0);
        check("t5_bm_cleared", b_mask_combinational, 4'b0011);
        tick();

        // resolve of a slot that is not live
        drive(3, 0, 0, -1, '0, '0);
        check("t6_clear", b_mask_clear, 4'b0000);
        check("t6_comb", b_mask_combinational, 4'b0011);
        tick();
        drive(-1, 0, 0, -1, '0, '0);
        check("t6_hold", b_mask_combinational, 4'b0011);
        tick();

        // asynchronous reset in the middle of a restore
        drive(-1, 0, 0, 2, rand_entry(), '0); tick();
        drive(2, 1, 32'h500, -1, '0, '0);
        check("t1_pre_rv", restore_valid, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("t1_comb", b_mask_combinational, 4'b0000);
        check("t1_rv", restore_valid, 1'b0);
        check("t1_squash", b_mask_squash, 4'b0000);
        q.delete();
        resolve_valid   = 1'b0;
        dispatch_b_mask = '0;
        @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        drive(-1, 0, 0, -1, '0, '0);
        check("t1_after", b_mask_combinational, 4'b0000);
        tick();

        // randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            int rs = -1;
            bit mis = 1'b0;
            if (q.size() > 0 && $urandom_range(2, 0) != 0) begin
                rs  = q[$urandom_range(q.size() - 1, 0)];
                mis = ($urandom_range(3, 0) == 0);
            end
            drive(rs, mis, $urandom, -2, rand_entry(), rand_retire());
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
